// File: rtl/auto_gain_control.sv
// -----------------------------------------------------------------------------
// auto_gain_control
//
// Chooses one of four front-end gains from the peak level of the ADC stream.
// The measurement runs in windows of WIN_SAMPLES samples. Any sample at or above
// DOWN_TH lowers the gain at once. A whole window whose peak stays below UP_TH
// raises it. Codes from UP_TH to DOWN_TH-1 form a dead band where the gain
// holds. After reset and after every gain change, the next SETTLE_SAMPLES
// samples are discarded so the relay and the analog path can settle.
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   adc_clk     in   1   ADC sample strobe, asynchronous to clk, one sample per
//                        rising edge
//   adc_data    in  12   unsigned ADC code, stable while adc_clk is high
//   relay_ctrl  out  2   gain select 00=3x 01=6.5x 10=13.5x 11=29.25x
//   stable      out  1   high while the gain is settled and being measured
// -----------------------------------------------------------------------------
module auto_gain_control #(
  parameter int          WIN_SAMPLES    = 16,
  parameter int          SETTLE_SAMPLES = 8,
  parameter logic [11:0] DOWN_TH        = 12'd3881,
  parameter logic [11:0] UP_TH          = 12'd1710
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_clk,
  input  logic [11:0] adc_data,
  output logic [1:0]  relay_ctrl,
  output logic        stable
);

  localparam int WCW = $clog2(WIN_SAMPLES + 1);
  localparam int SCW = $clog2(SETTLE_SAMPLES + 1);

  typedef enum logic {
    ST_SETTLE  = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  // Sample strobe: sample_valid is a single-clk pulse with no back-pressure.
  // adc_data is captured into sample_q on the clk edge that ends the pulse.
  // proc_q marks the following clk edge, where the FSM acts on sample_q.
  logic [2:0]     sync_q;   // [0],[1] synchronizer; [2] previous [1] for edge detect
  logic           sample_valid;
  logic [11:0]    sample_q;
  logic           proc_q;

  state_e         state_q, state_d;
  logic [SCW-1:0] settle_cnt_q, settle_cnt_d;
  logic [WCW-1:0] win_cnt_q, win_cnt_d;
  logic [11:0]    peak_q, peak_d;
  logic [1:0]     relay_q, relay_d;
  logic           stable_q, stable_d;
  logic [11:0]    peak_new;

  assign sample_valid = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      sample_q <= '0;
      proc_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], adc_clk};
      proc_q <= sample_valid;
      if (sample_valid) begin
        sample_q <= adc_data;
      end
    end
  end

  // The peak includes the sample being processed, so the window-end decision
  // sees the last sample of the window.
  assign peak_new = (sample_q > peak_q) ? sample_q : peak_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      peak_q       <= '0;
      relay_q      <= 2'b00;
      stable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      peak_q       <= peak_d;
      relay_q      <= relay_d;
      stable_q     <= stable_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    peak_d       = peak_q;
    relay_d      = relay_q;
    stable_d     = stable_q;

    if (proc_q) begin
      unique case (state_q)
        ST_SETTLE: begin
          // Sample values are discarded here; only the count matters.
          if (settle_cnt_q == SCW'(SETTLE_SAMPLES - 1)) begin
            state_d      = ST_MEASURE;
            settle_cnt_d = '0;
            win_cnt_d    = '0;
            peak_d       = '0;
            stable_d     = 1'b1;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end

        ST_MEASURE: begin
          if (sample_q >= DOWN_TH && relay_q != 2'b00) begin
            // Over-range wins over a coinciding window end.
            relay_d      = relay_q - 1'b1;
            stable_d     = 1'b0;
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
          end else if (win_cnt_q == WCW'(WIN_SAMPLES - 1)) begin
            if (peak_new < UP_TH && relay_q != 2'b11) begin
              relay_d      = relay_q + 1'b1;
              stable_d     = 1'b0;
              state_d      = ST_SETTLE;
              settle_cnt_d = '0;
            end else begin
              peak_d    = '0;
              win_cnt_d = '0;
            end
          end else begin
            // Over-range at the lowest gain lands here and the window goes on.
            peak_d    = peak_new;
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d = ST_SETTLE;
        end
      endcase
    end
  end

  assign relay_ctrl = relay_q;
  assign stable     = stable_q;

endmodule

// File: tb/tb_auto_gain_control.sv
// -----------------------------------------------------------------------------
// tb_auto_gain_control
//
// Directed bench for auto_gain_control at default parameters (16-sample window,
// 8-sample settle, thresholds 1710/3881). Each ADC sample is a strobe 10 clks
// high and 10 clks low. A sample is fully processed four clks after the strobe
// rises: two synchronizer flops, one edge-detect flop, and then the capture
// edge followed by the decision edge.
// -----------------------------------------------------------------------------
module tb_auto_gain_control;

  logic        clk;
  logic        rst;
  logic        adc_clk;
  logic [11:0] adc_data;
  logic [1:0]  relay_ctrl;
  logic        stable;

  int n_checks;
  int n_fail;

  auto_gain_control dut (
    .clk        (clk),
    .rst        (rst),
    .adc_clk    (adc_clk),
    .adc_data   (adc_data),
    .relay_ctrl (relay_ctrl),
    .stable     (stable)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] exp_relay, input logic exp_stable);
    check({tag, ".relay"}, {10'd0, relay_ctrl}, {10'd0, exp_relay});
    check({tag, ".stable"}, {11'd0, stable}, {11'd0, exp_stable});
  endtask

  // ---------------- drivers ----------------
  task automatic send_sample(input logic [11:0] d);
    @(negedge clk);
    adc_data = d;
    adc_clk  = 1'b1;
    repeat (10) @(negedge clk);
    adc_clk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_n(input logic [11:0] d, input int n);
    for (int i = 0; i < n; i++) send_sample(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_out("reset_hold", 2'b00, 1'b0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    adc_clk  = 1'b0;
    adc_data = 12'd0;

    // Reset state
    #1;
    check_out("async_reset", 2'b00, 1'b0);
    do_reset();

    // 0.9 V constant: settles after 8 samples, gain never moves
    send_n(12'd1843, 7);
    check_out("settle7_1843", 2'b00, 1'b0);
    send_sample(12'd1843);
    check_out("settle8_1843", 2'b00, 1'b1);
    for (int w = 0; w < 3; w++) begin
      send_n(12'd1843, 16);
      check_out("win_1843", 2'b00, 1'b1);
    end

    // Constant 600: climb one step per 24 samples up to 11
    for (int step = 1; step <= 3; step++) begin
      send_n(12'd600, 15);
      check_out("ramp_pre_end", 2'(step - 1), 1'b1);
      send_sample(12'd600);
      check_out("ramp_step", 2'(step), 1'b0);
      send_n(12'd600, 7);
      check_out("ramp_settle7", 2'(step), 1'b0);
      send_sample(12'd600);
      check_out("ramp_settle8", 2'(step), 1'b1);
    end
    send_n(12'd600, 16);
    check_out("ramp_saturate", 2'b11, 1'b1);

    // One 3900 sample at 11: decrease exactly one clk after capture
    @(negedge clk);
    adc_data = 12'd3900;
    adc_clk  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_out("over_capture_edge", 2'b11, 1'b1);
    @(posedge clk);
    #1;
    check_out("over_decision_edge", 2'b10, 1'b0);
    repeat (9) @(negedge clk);
    adc_clk = 1'b0;
    repeat (10) @(negedge clk);

    // Constant 2000 afterwards: settle, then hold at 10
    send_n(12'd2000, 8);
    check_out("post_over_settle", 2'b10, 1'b1);
    send_n(12'd2000, 32);
    check_out("post_over_2000", 2'b10, 1'b1);

    // Window peak 1710 holds, 1709 raises
    send_n(12'd1710, 16);
    check_out("peak_1710", 2'b10, 1'b1);
    send_n(12'd1709, 16);
    check_out("peak_1709", 2'b11, 1'b0);

    // 4000 inside SETTLE is ignored
    send_n(12'd1000, 3);
    send_sample(12'd4000);
    check_out("settle_4000", 2'b11, 1'b0);
    send_n(12'd1000, 3);
    check_out("settle_4000_s7", 2'b11, 1'b0);
    send_sample(12'd1000);
    check_out("settle_4000_s8", 2'b11, 1'b1);

    // Single 3880 holds, 3881 lowers
    send_sample(12'd3880);
    check_out("single_3880", 2'b11, 1'b1);
    send_sample(12'd3881);
    check_out("single_3881", 2'b10, 1'b0);

    // Reset mid-SETTLE at 10: outputs clear without a clk edge
    send_n(12'd1000, 3);
    check_out("pre_rst_mid_settle", 2'b10, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_mid_settle", 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Full settle required after reset
    send_n(12'd1843, 7);
    check_out("post_rst_settle7", 2'b00, 1'b0);
    send_sample(12'd1843);
    check_out("post_rst_settle8", 2'b00, 1'b1);

    // Over-range at 00 changes nothing; window continues to its end
    send_sample(12'd4000);
    check_out("over_at_00", 2'b00, 1'b1);
    send_n(12'd600, 15);
    check_out("over_at_00_winend", 2'b00, 1'b1);

    // Raise to 01, then a window whose last sample is over-range: decrease wins
    send_n(12'd600, 16);
    check_out("raise_to_01", 2'b01, 1'b0);
    send_n(12'd600, 8);
    check_out("settle_at_01", 2'b01, 1'b1);
    send_n(12'd600, 15);
    check_out("prio_pre", 2'b01, 1'b1);
    send_sample(12'd3900);
    check_out("prio_over_at_winend", 2'b00, 1'b0);

    // Reset mid-window: outputs clear immediately
    send_n(12'd600, 8);
    send_n(12'd600, 5);
    check_out("pre_rst_mid_window", 2'b00, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check_out("rst_mid_window", 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
